// File: rtl/friet_perm_axi4_lite.sv
// friet_perm_axi4_lite: AXI4-Lite slave wrapping the 24-round Friet-PC permutation (optional FRIET_CYCLE_COUNTER_EN)
module friet_perm_axi4_lite #(
  parameter int COMBINATIONAL_ROUNDS = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);
  localparam int CR = COMBINATIONAL_ROUNDS;
  localparam logic [31:0] RC [24] = '{
    32'h1111, 32'h11100000, 32'h1101, 32'h10100000, 32'h0101, 32'h10110000,
    32'h0110, 32'h11000000, 32'h1001, 32'h00100000, 32'h0100, 32'h00110000,
    32'h1110, 32'h10000000, 32'h0111, 32'h11110000, 32'h1010, 32'h01100000,
    32'h1011, 32'h11010000, 32'h0011, 32'h01000000, 32'h0100, 32'h11100000};
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [383:0] s, s_perm;
  logic [4:0] rnd;
  logic [31:0] rd_mux, reg_c;
  logic busy, last, wr_acc, rd_acc, start;
  logic [1:0] waddr, raddr;
  logic unused_ok;
  function automatic logic [127:0] rol(input logic [127:0] x, input int n);
    return (x << n) | (x >> (128 - n));
  endfunction
  function automatic logic [383:0] round_f(input logic [383:0] x, input logic [4:0] i);
    logic [127:0] a, b, c;
    a = x[127:0];
    b = x[255:128];
    c = x[383:256];
    c ^= {96'b0, RC[i]};
    {a, b, c} = {a ^ b ^ c, c, a};
    b ^= rol(c, 1);
    c ^= rol(b, 80);
    {a, b, c} = {b, a, a ^ b ^ c};
    a ^= rol(b, 36) & rol(c, 67);
    return {c, b, a};
  endfunction
  assign busy = state_q == RUN;
  assign last = rnd == 5'(24 - CR);
  assign waddr = s_axi_awaddr[3:2];
  assign raddr = s_axi_araddr[3:2];
  assign wr_acc = aresetn & s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~busy;
  assign s_axi_arready = aresetn & ~busy & ~s_axi_rvalid;
  assign rd_acc = s_axi_arvalid & s_axi_arready;
  assign start = wr_acc & (waddr == 2'd2) & s_axi_wdata[0];
  assign s_axi_awready = wr_acc;
  assign s_axi_wready = wr_acc;
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign unused_ok = ^{s_axi_awprot, s_axi_wstrb, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`ifdef FRIET_CYCLE_COUNTER_EN
  logic [31:0] cyc;
  // counts busy cycles of the most recent permutation
  always_ff @(posedge aclk)
    if (!aresetn) cyc <= '0;
    else if (start) cyc <= '0;
    else if (busy) cyc <= cyc + 32'd1;
  assign reg_c = cyc;
`else
  assign reg_c = '0;
`endif
  // unrolled rounds applied in one clock, starting at the current round index
  always_comb begin
    s_perm = s;
    for (int k = 0; k < CR; k++) s_perm = round_f(s_perm, rnd + 5'(k));
  end
  // read data selection by address
  always_comb
    rd_mux = raddr == 2'd0 ? s[31:0] : raddr == 2'd2 ? {31'b0, busy} : raddr == 2'd3 ? reg_c : 32'b0;
  // idle/run next state
  always_comb
    state_d = state_q == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  // state register
  always_ff @(posedge aclk)
    if (!aresetn) state_q <= IDLE;
    else state_q <= state_d;
  // datapath, round counter and AXI response registers
  always_ff @(posedge aclk)
    if (!aresetn) begin
      s <= '0;
      rnd <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
    end else begin
      if (busy) s <= s_perm;
      else if (wr_acc && waddr == 2'd1) s <= {s_axi_wdata, s[383:32]};
      else if (rd_acc && raddr == 2'd0) s <= {s[31:0], s[383:32]};
      rnd <= busy && !last ? rnd + 5'(CR) : 5'd0;
      s_axi_bvalid <= wr_acc | (s_axi_bvalid & ~s_axi_bready);
      s_axi_rvalid <= rd_acc | (s_axi_rvalid & ~s_axi_rready);
      if (rd_acc) s_axi_rdata <= rd_mux;
    end
endmodule

// File: tb/tb_friet_perm_axi4_lite.sv
// tb_friet_perm_axi4_lite: randomized bench with a behavioural Friet-PC/AXI model and per-cycle compare
module tb_friet_perm_axi4_lite;
  localparam int CR = 2;
  localparam int NCYC = 24 / CR;
  localparam logic [31:0] RCT [24] = '{
    32'h1111, 32'h11100000, 32'h1101, 32'h10100000, 32'h0101, 32'h10110000,
    32'h0110, 32'h11000000, 32'h1001, 32'h00100000, 32'h0100, 32'h00110000,
    32'h1110, 32'h10000000, 32'h0111, 32'h11110000, 32'h1010, 32'h01100000,
    32'h1011, 32'h11010000, 32'h0011, 32'h01000000, 32'h0100, 32'h11100000};
  logic aclk = 0, aresetn = 0;
  logic [3:0] awaddr = 0, araddr = 0, wstrb = 4'hf;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int cmp_n = 0, err_n = 0;
  logic [383:0] m = 0;
  int rem = 0, lc = 0, lat = 0;
  logic ebv = 0, erv = 0, meas = 0;
  logic [31:0] rq [$];
  friet_perm_axi4_lite #(.COMBINATIONAL_ROUNDS(CR)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready));
  always #5 aclk = ~aclk;
  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [127:0] rl(input logic [127:0] x, input int n);
    logic [255:0] d;
    d = {x, x} << n;
    return d[255:128];
  endfunction
  function automatic logic [383:0] friet(input logic [383:0] st, input int nr);
    logic [127:0] a, b, c, t;
    a = st[127:0];
    b = st[255:128];
    c = st[383:256];
    for (int i = 0; i < nr; i++) begin
      c = c ^ 128'(RCT[i]);
      t = a ^ b ^ c;
      b = c;
      c = a;
      a = t;
      b = b ^ rl(c, 1);
      c = c ^ rl(b, 80);
      c = a ^ b ^ c;
      t = a;
      a = b;
      b = t;
      a = a ^ (rl(b, 36) & rl(c, 67));
    end
    return {c, b, a};
  endfunction
  always @(posedge aclk) begin
    logic ea, ew;
    logic [31:0] v;
    if (!aresetn) begin
      m = 0; rem = 0; ebv = 0; erv = 0; lc = 0; meas = 0;
      rq.delete();
    end else begin
      ea = arvalid && rem == 0 && !erv;
      ew = awvalid && wvalid && rem == 0 && !ebv;
      if (rem > 0) rem--;
      if (erv && rready) begin erv = 0; rq.delete(0); end
      if (ebv && bready) ebv = 0;
      if (ea) begin
        v = 0;
        if (araddr[3:2] == 0) v = m[31:0];
`ifdef FRIET_CYCLE_COUNTER_EN
        if (araddr[3:2] == 3) v = lc;
`endif
        rq.push_back(v);
        erv = 1;
      end
      if (ew && awaddr[3:2] == 1) m = {wdata, m[383:32]};
      else if (ea && araddr[3:2] == 0) m = {m[31:0], m[383:32]};
      if (ew) begin
        ebv = 1;
        if (awaddr[3:2] == 2 && wdata[0]) begin
          m = friet(m, 24); rem = NCYC; lc = NCYC; meas = 1; lat = 0;
        end
      end
    end
  end
  always @(negedge aclk) begin
    if ($time > 5) begin
      chk("arready", arready, aresetn && rem == 0 && !erv);
      chk("awready", awready, aresetn && awvalid && wvalid && rem == 0 && !ebv);
      chk("wready", wready, aresetn && awvalid && wvalid && rem == 0 && !ebv);
      chk("bvalid", bvalid, ebv);
      chk("rvalid", rvalid, erv);
      if (erv) chk("rdata", rdata, rq[0]);
      if (erv) chk("rresp", rresp, 0);
      if (ebv) chk("bresp", bresp, 0);
      if (meas) begin
        if (arready) begin chk("latency", lat, NCYC); meas = 0; end
        else lat++;
      end
    end
  end
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input int bd);
    int t = 0;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    @(negedge aclk);
    while (!awready && t < 300) begin @(negedge aclk); t++; end
    chk("aw_handshake", awready, 1);
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    repeat (bd) begin @(posedge aclk); #1; end
    bready = 1;
    t = 0;
    @(negedge aclk);
    while (!bvalid && t < 300) begin @(negedge aclk); t++; end
    chk("b_handshake", bvalid, 1);
    @(posedge aclk); #1;
    bready = 0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] d, input int rdl);
    int t = 0;
    araddr = a; arvalid = 1;
    @(negedge aclk);
    while (!arready && t < 300) begin @(negedge aclk); t++; end
    chk("ar_handshake", arready, 1);
    @(posedge aclk); #1;
    arvalid = 0;
    repeat (rdl) begin @(posedge aclk); #1; end
    rready = 1;
    t = 0;
    @(negedge aclk);
    while (!rvalid && t < 300) begin @(negedge aclk); t++; end
    chk("r_handshake", rvalid, 1);
    d = rdata;
    @(posedge aclk); #1;
    rready = 0;
  endtask
  task automatic rst_check(input string tag);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] x;
    chk("model_pin_round0", friet(384'b0, 1), {128'h1111 << 80, 128'h1111, 128'h1111});
    repeat (2) @(posedge aclk);
    #1;
    rst_check("rst");
    aresetn = 1;
    rd(4'h8, x, 0);
    chk("status_after_rst", x, 0);
    for (int i = 0; i < 12; i++) wr(4'h4, i, 0);
    for (int i = 0; i < 12; i++) begin rd(4'h0, x, 0); chk("loopback", x, i); end
    rd(4'h0, x, 0);
    chk("loopback_13th", x, 0);
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 12; i++) wr(4'h4, v == 0 ? 32'h0 : $urandom, $urandom_range(0, 2));
      wr(4'h8, 32'h1, 0);
      for (int i = 0; i < 12; i++) rd(4'h0, x, $urandom_range(0, 3));
    end
    wr(4'h8, 32'h1, 0);
    fork
      rd(4'h8, x, 0);
      wr(4'hC, 32'h5, 0);
    join
    chk("status_after_busy", x, 0);
    wr(4'h8, 32'hFFFF_FFFE, 0);
    rd(4'h8, x, 0);
    chk("noop_start_status", x, 0);
    for (int i = 0; i < 12; i++) rd(4'h0, x, 0);
    rd(4'hC, x, 0);
`ifdef FRIET_CYCLE_COUNTER_EN
    chk("cycle_count", x, NCYC);
`else
    chk("reg_c_zero", x, 0);
`endif
    rd(4'h4, x, 0);
    chk("reg_4_zero", x, 0);
    rd(4'h0, x, 5);
    fork
      wr(4'h4, $urandom, 5);
      begin repeat (2) @(posedge aclk); #1; wr(4'h4, $urandom, 0); end
    join
    fork
      wr(4'h4, 32'hA5A5_0001, 0);
      rd(4'h0, x, 0);
    join
    for (int i = 0; i < 12; i++) rd(4'h0, x, $urandom_range(0, 1));
    wr(4'h8, 32'h1, 0);
    @(posedge aclk); #1;
    aresetn = 0;
    repeat (2) @(posedge aclk);
    #1;
    rst_check("midrst");
    aresetn = 1;
    rd(4'h0, x, 0);
    chk("midrst_state", x, 0);
    rd(4'h8, x, 0);
    chk("midrst_status", x, 0);
    repeat (3) @(posedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
